aes_inv_sub_bytes_seq: RTL and testbench

//   Multi-cycle AES InvSubBytes engine for the decryption datapath.

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_inv_sbox.sv | 46 ++++
 rtl/aes_inv_sub_bytes_seq.sv | 137 +++++++++++++
 tb/tb_aes_inv_sub_bytes_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse-cipher datapath blocks.
//   AES_BLOCK_W : state width in bits
//   AES_BYTES   : bytes per state
//   isb_state_e : InvSubBytes engine control states
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } isb_state_e;
endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box, purely combinational 256-entry lookup.
//   iData [7:0] : byte to substitute
//   oData [7:0] : InvSBox(iData)
module aes_inv_sbox (
  input  logic [7:0] iData,
  output logic [7:0] oData
);
  always_comb begin
    oData = 8'h00;
    case (iData)
      8'h00: oData = 8'h52; 8'h01: oData = 8'h09; 8'h02: oData = 8'h6a; 8'h03: oData = 8'hd5; 8'h04: oData = 8'h30; 8'h05: oData = 8'h36; 8'h06: oData = 8'ha5; 8'h07: oData = 8'h38;
      8'h08: oData = 8'hbf; 8'h09: oData = 8'h40; 8'h0a: oData = 8'ha3; 8'h0b: oData = 8'h9e; 8'h0c: oData = 8'h81; 8'h0d: oData = 8'hf3; 8'h0e: oData = 8'hd7; 8'h0f: oData = 8'hfb;
      8'h10: oData = 8'h7c; 8'h11: oData = 8'he3; 8'h12: oData = 8'h39; 8'h13: oData = 8'h82; 8'h14: oData = 8'h9b; 8'h15: oData = 8'h2f; 8'h16: oData = 8'hff; 8'h17: oData = 8'h87;
      8'h18: oData = 8'h34; 8'h19: oData = 8'h8e; 8'h1a: oData = 8'h43; 8'h1b: oData = 8'h44; 8'h1c: oData = 8'hc4; 8'h1d: oData = 8'hde; 8'h1e: oData = 8'he9; 8'h1f: oData = 8'hcb;
      8'h20: oData = 8'h54; 8'h21: oData = 8'h7b; 8'h22: oData = 8'h94; 8'h23: oData = 8'h32; 8'h24: oData = 8'ha6; 8'h25: oData = 8'hc2; 8'h26: oData = 8'h23; 8'h27: oData = 8'h3d;
      8'h28: oData = 8'hee; 8'h29: oData = 8'h4c; 8'h2a: oData = 8'h95; 8'h2b: oData = 8'h0b; 8'h2c: oData = 8'h42; 8'h2d: oData = 8'hfa; 8'h2e: oData = 8'hc3; 8'h2f: oData = 8'h4e;
      8'h30: oData = 8'h08; 8'h31: oData = 8'h2e; 8'h32: oData = 8'ha1; 8'h33: oData = 8'h66; 8'h34: oData = 8'h28; 8'h35: oData = 8'hd9; 8'h36: oData = 8'h24; 8'h37: oData = 8'hb2;
      8'h38: oData = 8'h76; 8'h39: oData = 8'h5b; 8'h3a: oData = 8'ha2; 8'h3b: oData = 8'h49; 8'h3c: oData = 8'h6d; 8'h3d: oData = 8'h8b; 8'h3e: oData = 8'hd1; 8'h3f: oData = 8'h25;
      8'h40: oData = 8'h72; 8'h41: oData = 8'hf8; 8'h42: oData = 8'hf6; 8'h43: oData = 8'h64; 8'h44: oData = 8'h86; 8'h45: oData = 8'h68; 8'h46: oData = 8'h98; 8'h47: oData = 8'h16;
      8'h48: oData = 8'hd4; 8'h49: oData = 8'ha4; 8'h4a: oData = 8'h5c; 8'h4b: oData = 8'hcc; 8'h4c: oData = 8'h5d; 8'h4d: oData = 8'h65; 8'h4e: oData = 8'hb6; 8'h4f: oData = 8'h92;
      8'h50: oData = 8'h6c; 8'h51: oData = 8'h70; 8'h52: oData = 8'h48; 8'h53: oData = 8'h50; 8'h54: oData = 8'hfd; 8'h55: oData = 8'hed; 8'h56: oData = 8'hb9; 8'h57: oData = 8'hda;
      8'h58: oData = 8'h5e; 8'h59: oData = 8'h15; 8'h5a: oData = 8'h46; 8'h5b: oData = 8'h57; 8'h5c: oData = 8'ha7; 8'h5d: oData = 8'h8d; 8'h5e: oData = 8'h9d; 8'h5f: oData = 8'h84;
      8'h60: oData = 8'h90; 8'h61: oData = 8'hd8; 8'h62: oData = 8'hab; 8'h63: oData = 8'h00; 8'h64: oData = 8'h8c; 8'h65: oData = 8'hbc; 8'h66: oData = 8'hd3; 8'h67: oData = 8'h0a;
      8'h68: oData = 8'hf7; 8'h69: oData = 8'he4; 8'h6a: oData = 8'h58; 8'h6b: oData = 8'h05; 8'h6c: oData = 8'hb8; 8'h6d: oData = 8'hb3; 8'h6e: oData = 8'h45; 8'h6f: oData = 8'h06;
      8'h70: oData = 8'hd0; 8'h71: oData = 8'h2c; 8'h72: oData = 8'h1e; 8'h73: oData = 8'h8f; 8'h74: oData = 8'hca; 8'h75: oData = 8'h3f; 8'h76: oData = 8'h0f; 8'h77: oData = 8'h02;
      8'h78: oData = 8'hc1; 8'h79: oData = 8'haf; 8'h7a: oData = 8'hbd; 8'h7b: oData = 8'h03; 8'h7c: oData = 8'h01; 8'h7d: oData = 8'h13; 8'h7e: oData = 8'h8a; 8'h7f: oData = 8'h6b;
      8'h80: oData = 8'h3a; 8'h81: oData = 8'h91; 8'h82: oData = 8'h11; 8'h83: oData = 8'h41; 8'h84: oData = 8'h4f; 8'h85: oData = 8'h67; 8'h86: oData = 8'hdc; 8'h87: oData = 8'hea;
      8'h88: oData = 8'h97; 8'h89: oData = 8'hf2; 8'h8a: oData = 8'hcf; 8'h8b: oData = 8'hce; 8'h8c: oData = 8'hf0; 8'h8d: oData = 8'hb4; 8'h8e: oData = 8'he6; 8'h8f: oData = 8'h73;
      8'h90: oData = 8'h96; 8'h91: oData = 8'hac; 8'h92: oData = 8'h74; 8'h93: oData = 8'h22; 8'h94: oData = 8'he7; 8'h95: oData = 8'had; 8'h96: oData = 8'h35; 8'h97: oData = 8'h85;
      8'h98: oData = 8'he2; 8'h99: oData = 8'hf9; 8'h9a: oData = 8'h37; 8'h9b: oData = 8'he8; 8'h9c: oData = 8'h1c; 8'h9d: oData = 8'h75; 8'h9e: oData = 8'hdf; 8'h9f: oData = 8'h6e;
      8'ha0: oData = 8'h47; 8'ha1: oData = 8'hf1; 8'ha2: oData = 8'h1a; 8'ha3: oData = 8'h71; 8'ha4: oData = 8'h1d; 8'ha5: oData = 8'h29; 8'ha6: oData = 8'hc5; 8'ha7: oData = 8'h89;
      8'ha8: oData = 8'h6f; 8'ha9: oData = 8'hb7; 8'haa: oData = 8'h62; 8'hab: oData = 8'h0e; 8'hac: oData = 8'haa; 8'had: oData = 8'h18; 8'hae: oData = 8'hbe; 8'haf: oData = 8'h1b;
      8'hb0: oData = 8'hfc; 8'hb1: oData = 8'h56; 8'hb2: oData = 8'h3e; 8'hb3: oData = 8'h4b; 8'hb4: oData = 8'hc6; 8'hb5: oData = 8'hd2; 8'hb6: oData = 8'h79; 8'hb7: oData = 8'h20;
      8'hb8: oData = 8'h9a; 8'hb9: oData = 8'hdb; 8'hba: oData = 8'hc0; 8'hbb: oData = 8'hfe; 8'hbc: oData = 8'h78; 8'hbd: oData = 8'hcd; 8'hbe: oData = 8'h5a; 8'hbf: oData = 8'hf4;
      8'hc0: oData = 8'h1f; 8'hc1: oData = 8'hdd; 8'hc2: oData = 8'ha8; 8'hc3: oData = 8'h33; 8'hc4: oData = 8'h88; 8'hc5: oData = 8'h07; 8'hc6: oData = 8'hc7; 8'hc7: oData = 8'h31;
      8'hc8: oData = 8'hb1; 8'hc9: oData = 8'h12; 8'hca: oData = 8'h10; 8'hcb: oData = 8'h59; 8'hcc: oData = 8'h27; 8'hcd: oData = 8'h80; 8'hce: oData = 8'hec; 8'hcf: oData = 8'h5f;
      8'hd0: oData = 8'h60; 8'hd1: oData = 8'h51; 8'hd2: oData = 8'h7f; 8'hd3: oData = 8'ha9; 8'hd4: oData = 8'h19; 8'hd5: oData = 8'hb5; 8'hd6: oData = 8'h4a; 8'hd7: oData = 8'h0d;
      8'hd8: oData = 8'h2d; 8'hd9: oData = 8'he5; 8'hda: oData = 8'h7a; 8'hdb: oData = 8'h9f; 8'hdc: oData = 8'h93; 8'hdd: oData = 8'hc9; 8'hde: oData = 8'h9c; 8'hdf: oData = 8'hef;
      8'he0: oData = 8'ha0; 8'he1: oData = 8'he0; 8'he2: oData = 8'h3b; 8'he3: oData = 8'h4d; 8'he4: oData = 8'hae; 8'he5: oData = 8'h2a; 8'he6: oData = 8'hf5; 8'he7: oData = 8'hb0;
      8'he8: oData = 8'hc8; 8'he9: oData = 8'heb; 8'hea: oData = 8'hbb; 8'heb: oData = 8'h3c; 8'hec: oData = 8'h83; 8'hed: oData = 8'h53; 8'hee: oData = 8'h99; 8'hef: oData = 8'h61;
      8'hf0: oData = 8'h17; 8'hf1: oData = 8'h2b; 8'hf2: oData = 8'h04; 8'hf3: oData = 8'h7e; 8'hf4: oData = 8'hba; 8'hf5: oData = 8'h77; 8'hf6: oData = 8'hd6; 8'hf7: oData = 8'h26;
      8'hf8: oData = 8'he1; 8'hf9: oData = 8'h69; 8'hfa: oData = 8'h14; 8'hfb: oData = 8'h63; 8'hfc: oData = 8'h55; 8'hfd: oData = 8'h21; 8'hfe: oData = 8'h0c; 8'hff: oData = 8'h7d;
      default: oData = 8'h00;
    endcase
  end
endmodule

// File: rtl/aes_inv_sub_bytes_seq.sv
// Multi-cycle AES InvSubBytes engine: captures one 128-bit state, substitutes
// LANES bytes per cycle through LANES inverse S-boxes, returns the result over
// a valid/ready handshake. One block in flight at a time.
//   iClk, iRst      : clock, async active-high reset
//   iValid/oReady   : input handshake (oReady only in IDLE)
//   iData [127:0]   : input state, byte0 = [127:120]
//   oValid/iReady   : output handshake (oValid only in DONE)
//   oData [127:0]   : result, driven straight from the state register
//   oBusy           : high in RUN or DONE
// Build option AES_ISB_OUTREG_EN: registers the S-box outputs before the
// state-register write; adds one fill cycle to RUN (latency STEPS+1).
module aes_inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [AES_BLOCK_W-1:0] iData,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [AES_BLOCK_W-1:0] oData,
  output logic                   oBusy
);
  localparam int STEPS = AES_BYTES / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  isb_state_e             r_st, w_st_nxt;
  logic [AES_BLOCK_W-1:0] r_state;
  logic [CW-1:0]          r_cnt;

  logic [LANES-1:0][7:0]  w_sb;      // S-box outputs for the lanes read this cycle
  logic [LANES-1:0][3:0]  w_rbyte;   // byte index each lane reads
  logic [LANES-1:0][3:0]  w_wbyte;   // byte index each lane writes
  logic [LANES-1:0][7:0]  w_wdata;
  logic [CW-1:0]          w_wcnt;
  logic                   w_wr_en;
  logic                   w_last;

  // Byte k lives at bits [(15-k)*8 +: 8]; for a 4-bit k, (15-k)*8 == {~k,3'b000}.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] w_in;
    assign w_rbyte[l] = 4'(int'(r_cnt) * LANES + l);
    assign w_wbyte[l] = 4'(int'(w_wcnt) * LANES + l);
    assign w_in       = r_state[{~w_rbyte[l], 3'b000} +: 8];
    aes_inv_sbox u_sbox (.iData(w_in), .oData(w_sb[l]));
  end

`ifdef AES_ISB_OUTREG_EN
  logic [LANES-1:0][7:0] r_sb_q;
  logic [CW-1:0]         r_wcnt;
  logic                  r_pvld;     // r_sb_q holds a lookup not yet written
  logic                  r_rd_done;  // every group has been looked up
  assign w_wr_en = (r_st == RUN) && r_pvld;
  assign w_wcnt  = r_wcnt;
  assign w_wdata = r_sb_q;
`else
  assign w_wr_en = (r_st == RUN);
  assign w_wcnt  = r_cnt;
  assign w_wdata = w_sb;
`endif

  assign w_last = w_wr_en && (w_wcnt == CW'(STEPS - 1));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_st <= IDLE;
    else      r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    oReady   = 1'b0;
    oValid   = 1'b0;
    oBusy    = 1'b1;
    oData    = r_state;
    case (r_st)
      IDLE: begin
        oReady = 1'b1;
        oBusy  = 1'b0;
        if (iValid) w_st_nxt = RUN;
      end
      RUN:  if (w_last) w_st_nxt = DONE;
      DONE: begin
        oValid = 1'b1;
        if (iReady) w_st_nxt = IDLE;
      end
      default: w_st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= '0;
      r_cnt   <= '0;
`ifdef AES_ISB_OUTREG_EN
      r_sb_q    <= '0;
      r_wcnt    <= '0;
      r_pvld    <= 1'b0;
      r_rd_done <= 1'b0;
`endif
    end else begin
      case (r_st)
        IDLE: if (iValid) begin
          r_state <= iData;
          r_cnt   <= '0;
`ifdef AES_ISB_OUTREG_EN
          r_pvld    <= 1'b0;
          r_rd_done <= 1'b0;
`endif
        end
        RUN: begin
          if (w_wr_en)
            for (int l = 0; l < LANES; l++)
              r_state[{~w_wbyte[l], 3'b000} +: 8] <= w_wdata[l];
`ifdef AES_ISB_OUTREG_EN
          // Read side runs one group ahead of the write side.
          if (!r_rd_done) begin
            r_sb_q <= w_sb;
            r_wcnt <= r_cnt;
            r_pvld <= 1'b1;
            if (r_cnt == CW'(STEPS - 1)) r_rd_done <= 1'b1;
            else                         r_cnt     <= r_cnt + CW'(1);
          end else begin
            r_pvld <= 1'b0;
          end
`else
          // Hold at STEPS-1 on the final group so cnt never leaves its range.
          if (!w_last) r_cnt <= r_cnt + CW'(1);
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
module tb_aes_inv_sub_bytes_seq;
  import aes_pkg::*;

`ifdef AES_ISB_OUTREG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         vin = 1'b0;
  logic [127:0] din = '0;
  logic         rdy = 1'b0;
  logic [2:0]   ordy, oval, obusy;
  logic [127:0] od [3];

  int checks = 0;
  int errors = 0;
  logic [127:0] sb [$];

  always #5 clk = ~clk;

  // Instance 0: LANES=4, 1: LANES=1, 2: LANES=16; all share the same stimulus.
  aes_inv_sub_bytes_seq #(.LANES(4)) u_l4 (
    .iClk(clk), .iRst(rst), .iValid(vin), .oReady(ordy[0]), .iData(din),
    .oValid(oval[0]), .iReady(rdy), .oData(od[0]), .oBusy(obusy[0]));
  aes_inv_sub_bytes_seq #(.LANES(1)) u_l1 (
    .iClk(clk), .iRst(rst), .iValid(vin), .oReady(ordy[1]), .iData(din),
    .oValid(oval[1]), .iReady(rdy), .oData(od[1]), .oBusy(obusy[1]));
  aes_inv_sub_bytes_seq #(.LANES(16)) u_l16 (
    .iClk(clk), .iRst(rst), .iValid(vin), .oReady(ordy[2]), .iData(din),
    .oValid(oval[2]), .iReady(rdy), .oData(od[2]), .oBusy(obusy[2]));

  function automatic int lat_exp(int i);
    case (i)
      0:       return 4 + EXTRA;
      1:       return 16 + EXTRA;
      default: return 1 + EXTRA;
    endcase
  endfunction

  // Golden model from GF(2^8) arithmetic: InvSBox(y) = inverse(InvAffine(y)).
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(logic [7:0] x);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] v, int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] isb(logic [7:0] y);
    return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] model(logic [127:0] d);
    logic [127:0] r = '0;
    for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = isb(d[127 - 8*k -: 8]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(&ordy) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_before_send", 128'(ordy), 128'(3'b111));
  endtask

  // Drive one block, push its expected result, measure each instance's
  // latency, optionally stall the output and inject ignored iValid pulses.
  task automatic send(input logic [127:0] d, input int hold, input bit noise,
                      output logic [127:0] got);
    int lat [3];
    logic [127:0] exp;
    wait_ready();
    vin = 1'b1; din = d;
    sb.push_back(model(d));
    @(posedge clk); #1;
    vin = 1'b0;
    lat = '{-1, -1, -1};
    for (int k = 1; k <= 40; k++) begin
      if (noise) begin
        vin = 1'b1;
        din = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) if (oval[i] && lat[i] < 0) lat[i] = k;
      if (!oval[0]) chk("run_oready_low", 128'(ordy[0]), 128'(0));
      if (&oval) break;
    end
    for (int i = 0; i < 3; i++) chk($sformatf("latency_l%0d", i), 128'(lat[i]), 128'(lat_exp(i)));
    exp = sb[0];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 128'(oval), 128'(3'b111));
      chk("hold_data", od[0], exp);
    end
    vin = 1'b0;
    exp = sb.pop_front();
    for (int i = 0; i < 3; i++) chk($sformatf("data_l%0d", i), od[i], exp);
    got = od[0];
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    chk("release_oready", 128'(ordy), 128'(3'b111));
    chk("release_ovalid", 128'(oval), 128'(3'b000));
  endtask

  initial begin
    logic [127:0] got;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_oready", 128'(ordy), 128'(3'b111));
    chk("rst_ovalid", 128'(oval), 128'(3'b000));
    chk("rst_obusy", 128'(obusy), 128'(3'b000));
    chk("rst_odata", od[0], 128'h0);
    rst = 1'b0;

    // All 0x63 -> zero
    send({16{8'h63}}, 0, 1'b0, got);
    chk("all63", got, 128'h0);

    // FIPS-style ramp
    send(128'h637c777bf26b6fc53001672bfed7ab76, 0, 1'b0, got);
    chk("ramp", got, 128'h000102030405060708090a0b0c0d0e0f);

    // Output stall for 10 cycles
    send({16{8'h16}}, 10, 1'b0, got);
    chk("stall16", got, {16{8'hff}});

    // Reset in RUN at cnt=2 on the LANES=4 instance
    wait_ready();
    vin = 1'b1; din = {16{8'h11}};
    @(posedge clk); #1;
    vin = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_busy", 128'(obusy[0]), 128'(1));
    rst = 1'b1;
    #1;
    chk("midrst_ovalid", 128'(oval), 128'(3'b000));
    chk("midrst_oready", 128'(ordy), 128'(3'b111));
    chk("midrst_odata", od[0], 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    send({16{8'h00}}, 0, 1'b0, got);
    chk("zero52", got, {16{8'h52}});

    // Random states against the golden model
    for (int r = 0; r < 4; r++)
      send({$urandom, $urandom, $urandom, $urandom}, r, 1'b0, got);

    // iValid noise during RUN/DONE must not disturb the captured block
    send(128'h0123456789abcdeffedcba9876543210, 3, 1'b1, got);
    chk("noise_block", got, model(128'h0123456789abcdeffedcba9876543210));

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
